// File: rtl/sn_decode_if.sv
// Register-bus and stream interface of the stochastic-to-binary decoder.
// The master side drives stream bits and bus writes; the slave side is the decoder.
interface sn_decode_if;
  logic        en;
  logic        sn_in_p;
  logic        sn_in_n;
  logic [31:0] data_in;
  logic        len_we;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        result_valid;

  modport master (
    output en, sn_in_p, sn_in_n, data_in, len_we, start,
    input  busy, done, result, result_valid
  );

  modport slave (
    input  en, sn_in_p, sn_in_n, data_in, len_we, start,
    output busy, done, result, result_valid
  );
endinterface

// File: rtl/sn_decode.sv
// Stochastic-to-binary decoder: accumulates a programmed number of stream bits into a
// signed 32-bit result using unipolar (0), bipolar (1) or two-line (2) encoding.
module sn_decode #(
  parameter logic [1:0] Mode = 2'd0
) (
  input logic       clk,
  input logic       rst_n,
  sn_decode_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  logic        [30:0] len_q, len_d;
  logic        [30:0] rem_q, rem_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic signed [31:0] step;

  // Bit 31 of the length write is reserved.
  logic unused_data_msb;
  assign unused_data_msb = bus.data_in[31];

  // Signed contribution of the current stream bit.
  always_comb begin
    step = '0;
    case (Mode)
      2'd0: step = {31'd0, bus.sn_in_p};
      2'd1: step = bus.sn_in_p ? 32'sd1 : -32'sd1;
      2'd2: begin
        if (bus.sn_in_p && !bus.sn_in_n) begin
          step = 32'sd1;
        end else if (bus.sn_in_n && !bus.sn_in_p) begin
          step = -32'sd1;
        end
      end
      default: step = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;

    if (bus.len_we) begin
      len_d = bus.data_in[30:0];
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // The old length is captured even when a length write lands in the same cycle.
          rem_d   = len_q;
          acc_d   = '0;
          valid_d = 1'b0;
          state_d = (len_q != '0) ? StRun : StFin;
        end
      end
      StRun: begin
        if (bus.en) begin
          acc_d = acc_q + step;
          rem_d = rem_q - 31'd1;
          if (rem_q == 31'd1) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        result_d = acc_q;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy         = (state_q == StRun);
  assign bus.done         = (state_q == StFin);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_sn_decode.sv
// Directed bench for sn_decode: one instance per encoding, hand-computed expected results,
// latencies and busy lengths, plus length-write, ignored-start and async-reset cases.
module tb_sn_decode;

  logic clk;
  logic rst_n;

  logic [2:0]  en_r, p_r, n_r, we_r, start_r;
  logic [31:0] data_r [3];
  logic [2:0]  busy_w, done_w, valid_w;
  logic [31:0] result_w [3];

  int n_cmp = 0;
  int n_err = 0;
  int prev_res [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sn_decode_if u_if ();
    assign u_if.en      = en_r[g];
    assign u_if.sn_in_p = p_r[g];
    assign u_if.sn_in_n = n_r[g];
    assign u_if.data_in = data_r[g];
    assign u_if.len_we  = we_r[g];
    assign u_if.start   = start_r[g];
    assign busy_w[g]    = u_if.busy;
    assign done_w[g]    = u_if.done;
    assign valid_w[g]   = u_if.result_valid;
    assign result_w[g]  = u_if.result;

    sn_decode #(.Mode(2'(g))) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int m, input logic [31:0] v);
    we_r[m]   = 1'b1;
    data_r[m] = v;
    tick();
    we_r[m]   = 1'b0;
  endtask

  // One decode on instance m. ev/elen give the EN pattern (1 beyond elen); st_at marks a
  // loop iteration with a stray START; we_at marks a length write (0 = in the START cycle).
  task automatic decode(input string tag, input int m, input int exp_res, input int exp_cyc,
                        input logic [15:0] pv, input logic [15:0] nv, input logic [15:0] ev,
                        input int elen, input int st_at, input int we_at,
                        input logic [31:0] we_val);
    int cyc = 0;
    int busy_cnt = 0;
    int bit_idx = 0;
    int i = 0;
    start_r[m] = 1'b1;
    en_r[m]    = 1'b0;
    we_r[m]    = (we_at == 0);
    data_r[m]  = we_val;
    tick();
    cyc++;
    start_r[m] = 1'b0;
    we_r[m]    = 1'b0;
    check({tag, "_valid_drop"}, 32'(valid_w[m]), 32'd0);
    check({tag, "_result_hold"}, result_w[m], prev_res[m]);
    while (!done_w[m] && i < 64) begin
      if (busy_w[m]) busy_cnt++;
      en_r[m]    = (i < elen) ? ev[i] : 1'b1;
      p_r[m]     = pv[bit_idx];
      n_r[m]     = nv[bit_idx];
      start_r[m] = (i == st_at);
      we_r[m]    = (i + 1 == we_at);
      data_r[m]  = we_val;
      tick();
      cyc++;
      if (en_r[m] && bit_idx < 15) bit_idx++;
      i++;
    end
    en_r[m]    = 1'b0;
    start_r[m] = 1'b0;
    we_r[m]    = 1'b0;
    check({tag, "_done_seen"}, 32'(done_w[m]), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    tick();
    check({tag, "_done_pulse"}, 32'(done_w[m]), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy_w[m]), 32'd0);
    check({tag, "_valid"}, 32'(valid_w[m]), 32'd1);
    check({tag, "_result"}, result_w[m], 32'(exp_res));
    prev_res[m] = exp_res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    en_r    = '0;
    p_r     = '0;
    n_r     = '0;
    we_r    = '0;
    start_r = '0;
    for (int k = 0; k < 3; k++) begin
      data_r[k]   = '0;
      prev_res[k] = 0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("rst_done%0d", k), 32'(done_w[k]), 32'd0);
      check($sformatf("rst_valid%0d", k), 32'(valid_w[k]), 32'd0);
      check($sformatf("rst_result%0d", k), result_w[k], 32'd0);
    end
    #10;
    rst_n = 1'b1;
    tick();

    // T1 unipolar: P=1,0,1,1,0,0,1,1 -> 5 ones, DONE LEN+1 = 9 cycles after START.
    set_len(0, 32'd8);
    decode("t1", 0, 5, 9, 16'h00CD, 16'h0000, 16'h0, 0, -1, -1, 32'd0);

    // T2 bipolar: P=1,1,1,0 -> 2; P=0,0,0,0 -> -4. N toggles to show it is ignored.
    set_len(1, 32'd4);
    decode("t2a", 1, 2, 5, 16'h0007, 16'h000A, 16'h0, 0, -1, -1, 32'd0);
    decode("t2b", 1, -4, 5, 16'h0000, 16'h000F, 16'h0, 0, -1, -1, 32'd0);

    // T3 two-line: (1,0),(0,1),(1,1),(0,1) -> +1 -1 0 -1 = -1.
    set_len(2, 32'd4);
    decode("t3", 2, -1, 5, 16'h0005, 16'h000E, 16'h0, 0, -1, -1, 32'd0);

    // T4 EN gaps 1,0,0,1,0,1 with P=1, stray START mid-run; then LEN=0.
    set_len(0, 32'd3);
    decode("t4", 0, 3, 7, 16'hFFFF, 16'h0000, 16'h0029, 6, 2, -1, 32'd0);
    set_len(0, 32'd0);
    decode("t4_len0", 0, 0, 1, 16'hFFFF, 16'h0000, 16'h0, 0, -1, -1, 32'd0);

    // T5 length write (bit 31 set, ignored) during a LEN=4 run; next run counts 10 bits.
    set_len(0, 32'd4);
    decode("t5a", 0, 3, 5, 16'h000B, 16'h0000, 16'h0, 0, -1, 2, 32'h8000_000A);
    decode("t5b", 0, 5, 11, 16'h02AA, 16'h0000, 16'h0, 0, -1, -1, 32'd0);

    // Length write in the START cycle: this run uses LEN=3, the next uses 6.
    set_len(1, 32'd3);
    decode("t5c", 1, 3, 4, 16'h0007, 16'h0000, 16'h0, 0, -1, 0, 32'd6);
    decode("t5d", 1, -4, 7, 16'h0001, 16'h0000, 16'h0, 0, -1, -1, 32'd0);

    // T6 asynchronous reset mid-run, then a fresh LEN=2 decode.
    set_len(2, 32'd8);
    start_r[2] = 1'b1;
    tick();
    start_r[2] = 1'b0;
    en_r[2] = 1'b1;
    p_r[2]  = 1'b1;
    n_r[2]  = 1'b0;
    tick();
    tick();
    check("t6_busy_before", 32'(busy_w[2]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    en_r = '0;
    check("t6_busy", 32'(busy_w[2]), 32'd0);
    check("t6_done", 32'(done_w[2]), 32'd0);
    check("t6_valid", 32'(valid_w[2]), 32'd0);
    check("t6_result", result_w[2], 32'd0);
    check("t6_result_mode0", result_w[0], 32'd0);
    check("t6_valid_mode0", 32'(valid_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) prev_res[k] = 0;
    set_len(2, 32'd2);
    decode("t6_after", 2, 2, 3, 16'h0003, 16'h0000, 16'h0, 0, -1, -1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
